// File: rtl/jkff_behavior.sv
// Clocked JK flip-flop bank with registered true and complement outputs.
// Each bit holds, clears, sets or toggles independently on the rising edge.
module jkff_behavior #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qbar;
  logic [WIDTH-1:0] w_q_next;

  // Characteristic equation: 00 hold, 01 clear, 10 set, 11 toggle, bitwise.
  always_comb begin
    w_q_next = (j & ~r_q) | (~k & r_q);
  end

  // qbar is its own register, loaded from the same next value as q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q    <= RESET_VAL;
      r_qbar <= ~RESET_VAL;
    end else begin
      r_q    <= w_q_next;
      r_qbar <= ~w_q_next;
    end
  end

  assign q    = r_q;
  assign qbar = r_qbar;

endmodule

// File: tb/tb_jkff_behavior.sv
// Directed bench for jkff_behavior: a single-bit instance and a 4-bit instance
// with a non-zero reset value, both on the same clock.
module tb_jkff_behavior;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       j1, k1;
  logic       q1, qbar1;
  logic [3:0] j4, k4;
  logic [3:0] q4, qbar4;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  jkff_behavior #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .j    (j1),
    .k    (k1),
    .q    (q1),
    .qbar (qbar1)
  );

  jkff_behavior #(.WIDTH(4), .RESET_VAL(4'b1010)) u_dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .j    (j4),
    .k    (k4),
    .q    (q4),
    .qbar (qbar4)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic exp_q);
    chk({tag, "_q"},    {3'b000, q1},    {3'b000, exp_q});
    chk({tag, "_qbar"}, {3'b000, qbar1}, {3'b000, ~exp_q});
  endtask

  initial begin
    rst_n = 1'b0;
    j1 = 1'b1; k1 = 1'b1;
    j4 = 4'b1111; k4 = 4'b1111;

    // Reset beats toggle on both instances.
    edge1();
    edge1();
    chk1("reset", 1'b0);
    chk("reset_q4",    q4,    4'b1010);
    chk("reset_qbar4", qbar4, 4'b0101);

    // Set, then stable for the rest of 100 ns.
    rst_n = 1'b1;
    j1 = 1'b1; k1 = 1'b0;
    j4 = 4'b0000; k4 = 4'b0000;
    edge1();
    chk1("set_first", 1'b1);
    for (int i = 0; i < 4; i++) begin
      edge1();
      chk1("set_hold", 1'b1);
    end
    chk("hold_q4", q4, 4'b1010);

    // Clear, then hold at 0.
    j1 = 1'b0; k1 = 1'b1;
    edge1();
    chk1("clr_first", 1'b0);
    for (int i = 0; i < 4; i++) begin
      edge1();
      chk1("clr_hold", 1'b0);
    end
    j1 = 1'b0; k1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge1();
      chk1("hold0", 1'b0);
    end

    // Toggle 1,0,1,0 then reset mid-toggle, then resume.
    j1 = 1'b1; k1 = 1'b1;
    edge1(); chk1("tog1", 1'b1);
    edge1(); chk1("tog2", 1'b0);
    edge1(); chk1("tog3", 1'b1);
    edge1(); chk1("tog4", 1'b0);
    edge1(); chk1("tog5", 1'b1);
    rst_n = 1'b0;
    edge1(); chk1("tog_rst", 1'b0);
    rst_n = 1'b1;
    edge1(); chk1("tog_resume", 1'b1);
    edge1(); chk1("tog_resume2", 1'b0);

    // Input change between edges is not visible until the next edge.
    j1 = 1'b0; k1 = 1'b1;
    edge1(); chk1("mid_pre", 1'b0);
    #4;
    j1 = 1'b1; k1 = 1'b0;
    #1;
    chk1("mid_after_change", 1'b0);
    #12;
    chk1("mid_before_edge", 1'b0);
    edge1(); chk1("mid_next_edge", 1'b1);

    // 4-bit mix: bit0 toggle, bit1 set, bit2 clear, bit3 hold from 1010.
    j4 = 4'b0011; k4 = 4'b0101;
    edge1();
    chk("mix_q4",    q4,    4'b1011);
    chk("mix_qbar4", qbar4, 4'b0100);
    edge1();
    chk("mix2_q4",   q4,    4'b1010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
